// File: rtl/mmss_timer.sv
// MM:SS up/down timer with run/stop, lap freeze, field adjust and a
// 4-digit multiplexed active-low 7-segment display driver.
module mmss_timer #(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000,
  parameter int MIN_MAX   = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_tgl,
  input  logic        lap_tgl,
  input  logic        adj,
  input  logic        sel,
  input  logic        mode,
  output logic [15:0] bcd,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        running,
  output logic        alarm,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_ADJ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ADJ_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    MAX10      = 4'(MIN_MAX / 10);
  localparam logic [3:0]    MAX1       = 4'(MIN_MAX % 10);

  state_t        state_q, state_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [AW-1:0] adj_cnt_q, adj_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          lap_hold_q, lap_hold_d;
  logic [15:0]   lap_q, lap_d;
  logic [3:0]    anodes_q, anodes_d;
  logic [6:0]    seg_q, seg_d;

  logic        sec_tick, adj_step, scan_last, blink_last, blank;
  logic [15:0] tick_val, disp;
  logic [3:0]  nib;

  function automatic logic [15:0] count_up(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd9) s1 = s1 + 4'd1;
    else begin
      s1 = 4'd0;
      if (s10 != 4'd5) s10 = s10 + 4'd1;
      else begin
        s10 = 4'd0;
        if (m10 == MAX10 && m1 == MAX1) begin m10 = 4'd0; m1 = 4'd0; end
        else if (m1 == 4'd9) begin m1 = 4'd0; m10 = m10 + 4'd1; end
        else m1 = m1 + 4'd1;
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  function automatic logic [15:0] count_down(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd0) s1 = s1 - 4'd1;
    else begin
      s1 = 4'd9;
      if (s10 != 4'd0) s10 = s10 - 4'd1;
      else begin
        s10 = 4'd5;
        if (m10 == 4'd0 && m1 == 4'd0) begin m10 = MAX10; m1 = MAX1; end
        else if (m1 == 4'd0) begin m1 = 4'd9; m10 = m10 - 4'd1; end
        else m1 = m1 - 4'd1;
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // Adjust bumps one field only; no carry into the other field.
  function automatic logic [15:0] adj_inc(input logic [15:0] v, input logic sec_sel);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (sec_sel) begin
      if (s10 == 4'd5 && s1 == 4'd9) begin s10 = 4'd0; s1 = 4'd0; end
      else if (s1 == 4'd9) begin s1 = 4'd0; s10 = s10 + 4'd1; end
      else s1 = s1 + 4'd1;
    end else begin
      if (m10 == MAX10 && m1 == MAX1) begin m10 = 4'd0; m1 = 4'd0; end
      else if (m1 == 4'd9) begin m1 = 4'd0; m10 = m10 + 4'd1; end
      else m1 = m1 + 4'd1;
    end
    return {m10, m1, s10, s1};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  assign sec_tick   = (state_q == S_RUN) && (presc_q == TICK_LAST);
  assign adj_step   = (state_q == S_ADJ) && (adj_cnt_q == ADJ_LAST);
  assign tick_val   = mode ? count_down(bcd_q) : count_up(bcd_q);
  assign scan_last  = (scan_cnt_q == SCAN_LAST);
  assign blink_last = (blink_cnt_q == BLINK_LAST);
  assign disp       = lap_hold_q ? lap_q : bcd_q;

  always_comb begin
    state_d = state_q;
    if (adj) state_d = S_ADJ;
    else begin
      case (state_q)
        S_STOP: if (pause_tgl && !(mode && bcd_q == 16'h0000)) state_d = S_RUN;
        S_RUN: begin
          if (pause_tgl) state_d = S_STOP;
          else if (sec_tick && mode && tick_val == 16'h0000) state_d = S_DONE;
        end
        S_ADJ:  state_d = S_STOP;
        S_DONE: if (pause_tgl) state_d = S_STOP;
        default: state_d = S_STOP;
      endcase
    end
  end

  always_comb begin
    bcd_d      = bcd_q;
    presc_d    = presc_q;
    adj_cnt_d  = '0;
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    if (sec_tick) bcd_d = tick_val;
    else if (adj_step) bcd_d = adj_inc(bcd_q, sel);
    // Prescaler only advances while staying in RUN; a fresh entry restarts it.
    if (state_q == S_RUN && state_d == S_RUN) presc_d = sec_tick ? '0 : presc_q + TW'(1);
    else if (state_d == S_RUN) presc_d = '0;
    if (state_q == S_ADJ) adj_cnt_d = adj_step ? '0 : adj_cnt_q + AW'(1);
    if (state_d != S_RUN) lap_hold_d = 1'b0;
    else if (state_q == S_RUN && lap_tgl) begin
      lap_hold_d = !lap_hold_q;
      if (!lap_hold_q) lap_d = bcd_q;
    end
  end

  always_comb begin
    scan_cnt_d  = scan_last ? '0 : scan_cnt_q + SW'(1);
    dig_d       = scan_last ? dig_q + 2'd1 : dig_q;
    blink_cnt_d = blink_last ? '0 : blink_cnt_q + BW'(1);
    blink_d     = blink_last ? !blink_q : blink_q;
    anodes_d    = ~(4'b1000 >> dig_d);
    case (dig_d)
      2'd0:    nib = disp[15:12];
      2'd1:    nib = disp[11:8];
      2'd2:    nib = disp[7:4];
      default: nib = disp[3:0];
    endcase
    // Digit slots 0/1 hold minutes, 2/3 seconds; dig_d[1] matches sel.
    blank = !blink_q && ((state_q == S_DONE) || (state_q == S_ADJ && dig_d[1] == sel));
    seg_d = blank ? 7'h7F : seg_decode(nib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_STOP;
      presc_q     <= '0;
      adj_cnt_q   <= '0;
      scan_cnt_q  <= '0;
      dig_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      bcd_q       <= 16'h0000;
      lap_hold_q  <= 1'b0;
      lap_q       <= 16'h0000;
      anodes_q    <= 4'b0111;
      seg_q       <= 7'b1000000;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      adj_cnt_q   <= adj_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      dig_q       <= dig_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      bcd_q       <= bcd_d;
      lap_hold_q  <= lap_hold_d;
      lap_q       <= lap_d;
      anodes_q    <= anodes_d;
      seg_q       <= seg_d;
    end
  end

  assign bcd       = bcd_q;
  assign anodes    = anodes_q;
  assign segments  = seg_q;
  assign running   = (state_q == S_RUN);
  assign alarm     = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench for mmss_timer: vector table for the counting/FSM paths,
// hand sequences for adjust blink, DONE blink, lap freeze and mid-run reset.
module tb_mmss_timer;
  localparam int TICK_DIV  = 10;
  localparam int ADJ_DIV   = 5;
  localparam int SCAN_DIV  = 2;
  localparam int BLINK_DIV = 4;
  localparam int MIN_MAX   = 2;
  localparam logic [1:0] ST_STOP = 2'd0, ST_RUN = 2'd1, ST_ADJ = 2'd2, ST_DONE = 2'd3;
  localparam logic [6:0] SEG_ZERO = 7'b1000000, SEG_BLANK = 7'h7F;

  logic        clk, rst, pause_tgl, lap_tgl, adj, sel, mode;
  logic [15:0] bcd;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        running, alarm;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  mmss_timer #(
    .TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV), .SCAN_DIV(SCAN_DIV),
    .BLINK_DIV(BLINK_DIV), .MIN_MAX(MIN_MAX)
  ) dut (
    .clk(clk), .rst(rst), .pause_tgl(pause_tgl), .lap_tgl(lap_tgl),
    .adj(adj), .sel(sel), .mode(mode), .bcd(bcd), .anodes(anodes),
    .segments(segments), .running(running), .alarm(alarm), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        pause;
    logic        lap;
    logic        adj;
    logic        sel;
    logic        mode;
    int          cycles;
    logic [15:0] exp_bcd;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic p, input logic l, input logic a, input logic s,
                              input logic m, input int c, input logic [15:0] b,
                              input logic [1:0] st);
    vec_t v;
    v.pause = p; v.lap = l; v.adj = a; v.sel = s; v.mode = m;
    v.cycles = c; v.exp_bcd = b; v.exp_st = st;
    return v;
  endfunction

  function automatic logic [3:0] seg2hex(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; pause_tgl = 1'b0; lap_tgl = 1'b0; adj = 1'b0; sel = 1'b0; mode = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic pulse_pause();
    pause_tgl = 1'b1; cyc(); pause_tgl = 1'b0;
  endtask

  task automatic pulse_lap();
    lap_tgl = 1'b1; cyc(); lap_tgl = 1'b0;
  endtask

  // One full scan round; assembles the shown value and counts bad anode patterns.
  task automatic read_display(output logic [15:0] val, output int bad_an);
    val = 16'hFFFF;
    bad_an = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      case (anodes)
        4'b0111: val[15:12] = seg2hex(segments);
        4'b1011: val[11:8]  = seg2hex(segments);
        4'b1101: val[7:4]   = seg2hex(segments);
        4'b1110: val[3:0]   = seg2hex(segments);
        default: bad_an++;
      endcase
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    adj = v.adj; sel = v.sel; mode = v.mode;
    pause_tgl = v.pause; lap_tgl = v.lap;
    cyc();
    pause_tgl = 1'b0; lap_tgl = 1'b0;
    repeat (v.cycles - 1) cyc();
    check($sformatf("vec%0d bcd", idx), 32'(bcd), 32'(v.exp_bcd));
    check($sformatf("vec%0d state", idx), 32'(dbg_state), 32'(v.exp_st));
    check($sformatf("vec%0d running", idx), 32'(running), 32'(v.exp_st == ST_RUN));
    check($sformatf("vec%0d alarm", idx), 32'(alarm), 32'(v.exp_st == ST_DONE));
  endtask

  initial begin
    logic [15:0] shown, exp_b;
    int bad_an, steps, s;
    int blank_sec, nb_sec, blank_min, n_blank, n_zero, n_other;

    vecs[0]  = mk(1, 0, 0, 0, 0, 601, 16'h0100, ST_RUN);
    vecs[1]  = mk(0, 0, 0, 0, 0,  10, 16'h0101, ST_RUN);
    vecs[2]  = mk(1, 0, 0, 0, 0,   1, 16'h0101, ST_STOP);
    vecs[3]  = mk(0, 0, 1, 0, 0,   6, 16'h0201, ST_ADJ);
    vecs[4]  = mk(0, 0, 1, 1, 0, 291, 16'h0259, ST_ADJ);
    vecs[5]  = mk(0, 0, 0, 1, 0,   1, 16'h0259, ST_STOP);
    vecs[6]  = mk(1, 0, 0, 0, 0,  11, 16'h0000, ST_RUN);
    vecs[7]  = mk(0, 0, 0, 0, 1,  10, 16'h0259, ST_RUN);
    vecs[8]  = mk(1, 0, 0, 0, 1,   1, 16'h0259, ST_STOP);
    vecs[9]  = mk(0, 0, 1, 0, 1,  11, 16'h0159, ST_ADJ);
    vecs[10] = mk(0, 0, 1, 1, 1,   5, 16'h0100, ST_ADJ);
    vecs[11] = mk(0, 0, 0, 0, 1,   1, 16'h0100, ST_STOP);
    vecs[12] = mk(1, 0, 0, 0, 1, 101, 16'h0050, ST_RUN);
    vecs[13] = mk(0, 0, 0, 0, 1, 500, 16'h0000, ST_DONE);
    vecs[14] = mk(1, 0, 0, 0, 1,   1, 16'h0000, ST_STOP);
    vecs[15] = mk(1, 0, 0, 0, 1,   1, 16'h0000, ST_STOP);
    vecs[16] = mk(0, 0, 0, 0, 1,  20, 16'h0000, ST_STOP);
    vecs[17] = mk(1, 0, 0, 0, 0,  41, 16'h0004, ST_RUN);
    vecs[18] = mk(1, 1, 0, 0, 0,   1, 16'h0004, ST_STOP);
    vecs[19] = mk(1, 0, 0, 0, 0,   1, 16'h0004, ST_RUN);
    vecs[20] = mk(1, 0, 1, 0, 0,   1, 16'h0004, ST_ADJ);
    vecs[21] = mk(0, 0, 0, 0, 0,   1, 16'h0004, ST_STOP);

    rst = 1'b1; pause_tgl = 1'b0; lap_tgl = 1'b0; adj = 1'b0; sel = 1'b0; mode = 1'b0;
    #2 rst = 1'b0;
    repeat (3) cyc();
    check("reset bcd", 32'(bcd), 32'h0000);
    check("reset state", 32'(dbg_state), 32'(ST_STOP));
    check("reset running", 32'(running), 32'd0);
    check("reset alarm", 32'(alarm), 32'd0);
    check("reset anodes", 32'(anodes), 32'(4'b0111));
    check("reset segments", 32'(segments), 32'(SEG_ZERO));
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 22; i++) apply_vec(vecs[i], i);

    // Adjust seconds from 00:58 with blink on the selected field.
    do_reset();
    adj = 1'b1; sel = 1'b1;
    repeat (291) cyc();
    check("adj preset", 32'(bcd), 32'h0058);
    adj = 1'b0;
    cyc();
    check("adj preset stop", 32'(dbg_state), 32'(ST_STOP));
    adj = 1'b1; sel = 1'b1;
    blank_sec = 0; nb_sec = 0; blank_min = 0;
    for (int k = 1; k <= 26; k++) begin
      cyc();
      steps = (k - 1) / 5;
      s = (58 + steps) % 60;
      exp_b = {8'h00, 4'(s / 10), 4'(s % 10)};
      check($sformatf("adj step k=%0d", k), 32'(bcd), 32'(exp_b));
      if (k > 1) begin
        if (anodes[1] == 1'b0 || anodes[0] == 1'b0) begin
          if (segments == SEG_BLANK) blank_sec++;
          else nb_sec++;
        end else if (segments == SEG_BLANK) blank_min++;
      end
    end
    check("adj sec blank seen", 32'(blank_sec > 0), 32'd1);
    check("adj sec lit seen", 32'(nb_sec > 0), 32'd1);
    check("adj min never blank", 32'(blank_min), 32'd0);
    adj = 1'b0;
    repeat (2) cyc();
    n_blank = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (segments == SEG_BLANK) n_blank++;
    end
    check("stop no blank", 32'(n_blank), 32'd0);

    // Count down 00:01 into DONE and watch the all-digit blink.
    do_reset();
    adj = 1'b1; sel = 1'b1;
    repeat (6) cyc();
    adj = 1'b0;
    cyc();
    mode = 1'b1;
    pulse_pause();
    repeat (10) cyc();
    check("done bcd", 32'(bcd), 32'h0000);
    check("done alarm", 32'(alarm), 32'd1);
    check("done state", 32'(dbg_state), 32'(ST_DONE));
    n_blank = 0; n_zero = 0; n_other = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (segments == SEG_BLANK) n_blank++;
      else if (segments == SEG_ZERO) n_zero++;
      else n_other++;
    end
    check("done blank seen", 32'(n_blank > 0), 32'd1);
    check("done zero seen", 32'(n_zero > 0), 32'd1);
    check("done other segs", 32'(n_other), 32'd0);

    // Lap freeze, release, and simultaneous pause+lap clearing the hold.
    do_reset();
    mode = 1'b0;
    pulse_pause();
    repeat (30) cyc();
    check("lap pre bcd", 32'(bcd), 32'h0003);
    pulse_lap();
    repeat (10) cyc();
    read_display(shown, bad_an);
    check("lap frozen display", 32'(shown), 32'h0003);
    check("lap frozen anodes", 32'(bad_an), 32'd0);
    check("lap live bcd 4", 32'(bcd), 32'h0004);
    repeat (11) cyc();
    check("lap live bcd 6", 32'(bcd), 32'h0006);
    pulse_lap();
    read_display(shown, bad_an);
    check("lap released display", 32'(shown), 32'h0006);
    cyc();
    pause_tgl = 1'b1; lap_tgl = 1'b1;
    cyc();
    pause_tgl = 1'b0; lap_tgl = 1'b0;
    check("pause+lap state", 32'(dbg_state), 32'(ST_STOP));
    check("pause+lap bcd", 32'(bcd), 32'h0007);
    pulse_pause();
    repeat (10) cyc();
    check("rerun bcd", 32'(bcd), 32'h0008);
    read_display(shown, bad_an);
    check("rerun live display", 32'(shown), 32'h0008);

    // Asynchronous reset in the middle of a second.
    do_reset();
    mode = 1'b0;
    pulse_pause();
    repeat (70) cyc();
    check("mid-run bcd", 32'(bcd), 32'h0007);
    repeat (5) cyc();
    #2 rst = 1'b0;
    #1;
    check("async rst bcd", 32'(bcd), 32'h0000);
    check("async rst running", 32'(running), 32'd0);
    check("async rst anodes", 32'(anodes), 32'(4'b0111));
    check("async rst segments", 32'(segments), 32'(SEG_ZERO));
    #1 rst = 1'b1;
    cyc();
    check("post rst state", 32'(dbg_state), 32'(ST_STOP));
    pulse_pause();
    repeat (9) cyc();
    check("post rst no early tick", 32'(bcd), 32'h0000);
    cyc();
    check("post rst first tick", 32'(bcd), 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
